mxv_rest_sequencer: RTL

- Initiator-side controller for the MxV datapath's rest/settle counter.
- On `start`, walks an N_ROWS x N_COLS matrix in row-major order, issuing one MAC strobe per column with row/column indices.
- After each row it raises `rest_enable` to the rest counter and waits for that counter's `pass` before issuing the next row.
- Ends each run with a `done` pulse, or with a sticky `error` if the rest counter never answers.

---
 rtl/mxv_rest_sequencer_if.sv | 26 ++
 rtl/mxv_rest_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mxv_rest_sequencer_if.sv
// Handshake bundle between the MxV rest sequencer and its environment.
// master = sequencer side, slave = requester / rest-counter side.
interface mxv_rest_sequencer_if #(
    parameter int IDX_W = 3
);
    logic             start;
    logic             rest_pass;
    logic             rest_enable;
    logic             mac_valid;
    logic [IDX_W-1:0] row_idx;
    logic [IDX_W-1:0] col_idx;
    logic             row_done;
    logic             busy;
    logic             done;
    logic             error;

    modport master (
        input  start, rest_pass,
        output rest_enable, mac_valid, row_idx, col_idx, row_done, busy, done, error
    );

    modport slave (
        output start, rest_pass,
        input  rest_enable, mac_valid, row_idx, col_idx, row_done, busy, done, error
    );
endinterface

// File: rtl/mxv_rest_sequencer.sv
// Walks an N_ROWS x N_COLS matrix row-major, one MAC strobe per column, resting between rows.
// Latency: first mac_valid one cycle after start is sampled; all outputs registered.
// Backpressure: next row waits for a qualified rest_pass; no pass within REST_TIMEOUT -> sticky error.
module mxv_rest_sequencer #(
    parameter int N_ROWS       = 4,
    parameter int N_COLS       = 4,
    parameter int IDX_W        = 3,
    parameter int REST_TIMEOUT = 16,
    parameter int TMO_W        = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    mxv_rest_sequencer_if.master  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_REST, S_FINISH} state_t;

    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(N_COLS - 1);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(N_ROWS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(REST_TIMEOUT - 1);
    localparam logic             ONE_COL  = (N_COLS == 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] row_q, row_d, col_q, col_d;
    logic [IDX_W-1:0] row_inc, col_inc;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             rest_en_q, rest_en_d;
    logic             mac_q, mac_d;
    logic             row_done_q, row_done_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    assign row_inc = row_q + IDX_W'(1);
    assign col_inc = col_q + IDX_W'(1);

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        tmo_d      = tmo_q;
        rest_en_d  = rest_en_q;
        mac_d      = 1'b0;
        row_done_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                busy_d    = 1'b0;
                rest_en_d = 1'b0;
                if (bus.start) begin
                    err_d      = 1'b0;
                    row_d      = '0;
                    col_d      = '0;
                    mac_d      = 1'b1;
                    row_done_d = ONE_COL;
                    busy_d     = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (col_q == LAST_COL) begin
                    rest_en_d = 1'b1;
                    tmo_d     = '0;
                    state_d   = S_REST;
                end else begin
                    col_d      = col_inc;
                    mac_d      = 1'b1;
                    row_done_d = (col_inc == LAST_COL);
                end
            end
            S_REST: begin
                // The first REST edge may still see the previous row's pass; only trust it afterwards.
                if ((tmo_q != '0) && bus.rest_pass) begin
                    rest_en_d = 1'b0;
                    if (row_q == LAST_ROW) begin
                        done_d  = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        row_d      = row_inc;
                        col_d      = '0;
                        mac_d      = 1'b1;
                        row_done_d = ONE_COL;
                        state_d    = S_ISSUE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d     = 1'b1;
                    rest_en_d = 1'b0;
                    busy_d    = 1'b0;
                    row_d     = '0;
                    col_d     = '0;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                row_d   = '0;
                col_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            tmo_q      <= '0;
            rest_en_q  <= 1'b0;
            mac_q      <= 1'b0;
            row_done_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            tmo_q      <= tmo_d;
            rest_en_q  <= rest_en_d;
            mac_q      <= mac_d;
            row_done_q <= row_done_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.rest_enable = rest_en_q;
    assign bus.mac_valid   = mac_q;
    assign bus.row_idx     = row_q;
    assign bus.col_idx     = col_q;
    assign bus.row_done    = row_done_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = err_q;
endmodule
